// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared state encoding and stream geometry for the instruction memory loader.
package im_loader_pkg;
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR} state_t;
    localparam int WORD_BYTES = 4;
    localparam int HDR_W      = 16;
endpackage

// File: rtl/im_loader_pack.sv
// im_loader_pack: big-endian byte-to-word assembly register with a byte counter.
module im_loader_pack
    import im_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic                    i_valid,
    input  logic [7:0]              i_data,
    output logic [8*WORD_BYTES-1:0] o_word,
    output logic                    o_word_ready
);
    localparam int CW = $clog2(WORD_BYTES);

    logic [8*WORD_BYTES-1:0] r_word;
    logic [CW-1:0]           r_cnt;

    // word_ready marks the byte that completes a word, so the FSM can enter WRITE on that edge
    assign o_word_ready = i_valid && (r_cnt == CW'(WORD_BYTES - 1));
    assign o_word       = r_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_clr) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_valid) begin
            r_word <= {r_word[8*WORD_BYTES-9:0], i_data};
            r_cnt  <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/im_loader.sv
// im_loader: boot-time writer that streams a length-prefixed byte image into instruction memory.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int          NMEM       = 20,
    parameter logic [31:0] START_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int KW = $clog2(NMEM + 1);

    state_t           r_state, w_next;
    logic [HDR_W-1:0] r_len;
    logic [KW-1:0]    r_k;
    logic [31:0]      r_addr;
    logic             w_go, w_xfer, w_word_ready, w_k_last;
    logic [HDR_W-1:0] w_len_full;

    assign w_go       = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
    assign in_ready   = r_state == LEN_HI || r_state == LEN_LO || r_state == DATA;
    assign w_xfer     = in_valid && in_ready;
    assign w_len_full = {r_len[HDR_W-1:8], in_data};
    assign w_k_last   = (HDR_W'(r_k) + HDR_W'(1)) == r_len;

    im_loader_pack u_pack (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (w_go),
        .i_valid      (w_xfer && r_state == DATA),
        .i_data       (in_data),
        .o_word       (im_wdata),
        .o_word_ready (w_word_ready)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (w_go) w_next = LEN_HI;
            LEN_HI: if (w_xfer) w_next = LEN_LO;
            LEN_LO: if (w_xfer) w_next = (w_len_full == '0) ? DONE :
                                         (w_len_full > HDR_W'(NMEM)) ? ERR : DATA;
            DATA:   if (w_word_ready) w_next = WRITE;
            WRITE:  w_next = w_k_last ? DONE : DATA;
            DONE:   if (w_go) w_next = LEN_HI;
            ERR:    if (w_go) w_next = LEN_HI;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_k     <= '0;
            r_addr  <= START_ADDR;
        end else begin
            r_state <= w_next;
            if (w_go) begin
                r_len <= '0;
                r_k   <= '0;
            end
            if (r_state == LEN_HI && w_xfer) r_len[HDR_W-1:8] <= in_data;
            if (r_state == LEN_LO && w_xfer) begin
                r_len[7:0] <= in_data;
                r_k        <= '0;
            end
            // address is captured with the last byte so it only moves when a write is issued
            if (r_state == DATA && w_word_ready) r_addr <= START_ADDR + (32'(r_k) << 2);
            if (r_state == WRITE) r_k <= r_k + KW'(1);
        end
    end

    assign im_we   = r_state == WRITE;
    assign im_addr = r_addr;
    assign busy    = r_state == LEN_HI || r_state == LEN_LO || r_state == DATA || r_state == WRITE;
    assign done    = r_state == DONE;
    assign err     = r_state == ERR;
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: randomized self-checking bench for im_loader at two base addresses.
module tb_im_loader;
    localparam int NMEM = 20;
    localparam logic [31:0] BASE1 = 32'h100;

    logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
    logic [7:0] in_data = 0;
    logic rdy0, we0, busy0, done0, err0, rdy1, we1, busy1, done1, err1;
    logic [31:0] addr0, wd0, addr1, wd1;

    int n_assert = 0, n_fail = 0;
    logic [7:0]  tx[$];
    logic [31:0] exp_d[$], a0[$], d0[$], a1[$], d1[$];

    always #5 clk = ~clk;

    im_loader #(.NMEM(NMEM), .START_ADDR(32'h0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .im_we(we0), .im_addr(addr0), .im_wdata(wd0),
        .busy(busy0), .done(done0), .err(err0));

    im_loader #(.NMEM(NMEM), .START_ADDR(BASE1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .im_we(we1), .im_addr(addr1), .im_wdata(wd1),
        .busy(busy1), .done(done1), .err(err1));

    // write monitor: captures every strobe and checks that input is stalled while writing
    always @(negedge clk) begin
        if (rst_n && we0) begin
            a0.push_back(addr0); d0.push_back(wd0);
            n_assert++;
            if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL ready_in_write dut0 got %b want 0", rdy0); end
        end
        if (rst_n && we1) begin
            a1.push_back(addr1); d1.push_back(wd1);
            n_assert++;
            if (rdy1 !== 1'b0) begin n_fail++; $display("FAIL ready_in_write dut1 got %b want 0", rdy1); end
        end
    end

    task automatic check_idle_outputs(input string tag);
        n_assert++;
        if ({rdy0, we0, busy0, done0, err0} !== 5'b0 || addr0 !== 32'h0 || wd0 !== 32'h0) begin
            n_fail++;
            $display("FAIL %s dut0 got rdy/we/busy/done/err=%b addr=%h wdata=%h want 0 0 0", tag,
                     {rdy0, we0, busy0, done0, err0}, addr0, wd0);
        end
        n_assert++;
        if ({rdy1, we1, busy1, done1, err1} !== 5'b0 || addr1 !== BASE1 || wd1 !== 32'h0) begin
            n_fail++;
            $display("FAIL %s dut1 got rdy/we/busy/done/err=%b addr=%h wdata=%h want 0 %h 0", tag,
                     {rdy1, we1, busy1, done1, err1}, addr1, wd1, BASE1);
        end
    endtask

    task automatic do_start();
        @(negedge clk); start = 1; in_valid = 0;
        @(negedge clk); start = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            in_data  = b;
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            start    = gaps && ($urandom_range(0, 7) == 0);
            got      = in_valid && rdy0;
        end
        n_assert++;
        if (!got) begin n_fail++; $display("FAIL byte_accept got no transfer in 200 cycles want transfer of %h", b); end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) tx.push_back(8'(w >> (8 * i)));
    endtask

    task automatic make_img(input int n, input int words);
        tx.delete();
        tx.push_back(8'(n >> 8)); tx.push_back(8'(n));
        for (int i = 0; i < words; i++) push_word($urandom);
    endtask

    task automatic run_img(input bit gaps);
        int n;
        n = {tx[0], tx[1]};
        exp_d.delete();
        if (n > 0 && n <= NMEM)
            for (int w = 0; w < n; w++)
                exp_d.push_back({tx[2 + 4*w], tx[3 + 4*w], tx[4 + 4*w], tx[5 + 4*w]});
        a0.delete(); d0.delete(); a1.delete(); d1.delete();
        do_start();
        foreach (tx[i]) send_byte(tx[i], gaps);
        @(negedge clk); in_valid = 0; start = 0;
        n_assert++;
        if (n > NMEM) begin
            if ({err0, err1, rdy0, busy0, done0} !== 5'b11000) begin
                n_fail++; $display("FAIL overflow n=%0d got err0/err1/rdy/busy/done=%b want 11000", n, {err0, err1, rdy0, busy0, done0});
            end
        end else if (n == 0) begin
            if ({done0, done1, busy0, err0, rdy0} !== 5'b11000) begin
                n_fail++; $display("FAIL zero_len got done0/done1/busy/err/rdy=%b want 11000", {done0, done1, busy0, err0, rdy0});
            end
        end else begin
            if ({we0, we1, rdy0, busy0} !== 4'b1101) begin
                n_fail++; $display("FAIL last_write n=%0d got we0/we1/rdy/busy=%b want 1101", n, {we0, we1, rdy0, busy0});
            end
            @(negedge clk);
            n_assert++;
            if ({done0, done1, busy0, we0, err0} !== 5'b11000) begin
                n_fail++; $display("FAIL done_after_write n=%0d got done0/done1/busy/we/err=%b want 11000", n, {done0, done1, busy0, we0, err0});
            end
        end
        repeat (3) @(negedge clk);
        n_assert++;
        if (a0.size() != exp_d.size() || a1.size() != exp_d.size()) begin
            n_fail++; $display("FAIL write_count n=%0d got %0d/%0d want %0d", n, a0.size(), a1.size(), exp_d.size());
        end else begin
            foreach (exp_d[i]) begin
                n_assert++;
                if (a0[i] !== 32'(4*i) || d0[i] !== exp_d[i] || a1[i] !== BASE1 + 32'(4*i) || d1[i] !== exp_d[i]) begin
                    n_fail++;
                    $display("FAIL write[%0d] got %h:%h / %h:%h want %h:%h / %h:%h", i, a0[i], d0[i], a1[i], d1[i],
                             32'(4*i), exp_d[i], BASE1 + 32'(4*i), exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_asserted");
        rst_n = 1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_released");
    endtask

    task automatic test_basic();
        tx.delete();
        tx.push_back(8'h00); tx.push_back(8'h03);
        push_word(32'h20000000); push_word(32'h20800000); push_word(32'h01000820);
        run_img(0);
    endtask

    task automatic test_zero();
        make_img(0, 0);
        run_img(0);
    endtask

    task automatic test_overflow();
        make_img(NMEM + 1, 0);
        run_img(0);
        make_img(16'h0103, 0);
        run_img(0);
        make_img(1, 1);
        run_img(0);
    endtask

    task automatic test_full_depth();
        make_img(NMEM, NMEM);
        run_img(0);
    endtask

    task automatic test_gaps();
        for (int t = 0; t < 5; t++) begin
            make_img(0, 0);
            tx.delete();
            make_img($urandom_range(1, NMEM), 0);
            for (int w = 0; w < {tx[0], tx[1]}; w++) push_word($urandom);
            run_img(1);
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 3; t++) begin
            make_img($urandom_range(1, 6), 0);
            for (int w = 0; w < {tx[0], tx[1]}; w++) push_word($urandom);
            run_img(0);
        end
    endtask

    task automatic test_reset_mid();
        a0.delete(); d0.delete(); a1.delete(); d1.delete();
        do_start();
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        check_idle_outputs("reset_mid_async");
        @(negedge clk); rst_n = 1; in_valid = 1; in_data = 8'hCC;
        repeat (10) @(negedge clk);
        in_valid = 0;
        n_assert++;
        if (a0.size() != 0 || a1.size() != 0 || rdy0 !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_quiet got writes=%0d/%0d rdy=%b busy=%b want 0/0 0 0", a0.size(), a1.size(), rdy0, busy0);
        end
        make_img(2, 2);
        run_img(0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_overflow();
        test_full_depth();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Boot-time writer for the instruction memory. It is the write-side counterpart of the PC-driven read path.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word through a one-cycle write strobe to consecutive word addresses, starting at START_ADDR.
- Asserts done when the image is loaded; the CPU's PC is held off until then.

Parameters:
- NMEM, 20: instruction memory depth in words; maximum accepted word count.
- START_ADDR, 0: byte address of the first word written; must be a multiple of 4.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader can accept a byte; a transfer occurs when in_valid and in_ready are both 1 on a posedge.
- im_we  out  1  instruction memory write strobe, one cycle per word.
- im_addr  out  32  byte address of the current write.
- im_wdata  out  32  word being written.
- busy  out  1  load in progress.
- done  out  1  image fully written; held until the next start.
- err  out  1  header word count exceeded NMEM; held until the next start.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - in_ready, im_we, busy, done, err = 0; im_addr = START_ADDR; im_wdata = 0.
  - Internal byte counter, word counter and length register = 0.
  - Reset mid-load abandons the load. No further im_we is issued; memory contents already written are left as is.
- Stream format:
  - 2-byte big-endian word count N (high byte first).
  - Followed by N words of 4 bytes each, most significant byte first.
- States:
  - IDLE: in_ready=0. On start → LEN_HI.
  - LEN_HI: in_ready=1, busy=1. On transfer, latch N[15:8] → LEN_LO.
  - LEN_LO: in_ready=1, busy=1. On transfer, latch N[7:0], then branch:
    - N==0 → DONE.
    - N>NMEM → ERR.
    - Otherwise → DATA, with word counter k=0.
  - DATA: in_ready=1, busy=1. Shift each transferred byte into the assembly register. After the 4th byte → WRITE.
  - WRITE: lasts exactly one cycle.
    - in_ready=0, busy=1, im_we=1.
    - im_addr = START_ADDR + 4*k; im_wdata = assembled word.
    - Next cycle, k increments. If k+1==N → DONE, else → DATA.
  - DONE: done=1, busy=0, in_ready=0. On start → LEN_HI, clearing done.
  - ERR: err=1, busy=0, in_ready=0. No writes occur. On start → LEN_HI, clearing err.
- im_we and im_addr/im_wdata are registered outputs. They are valid in the same cycle, and im_we is never asserted outside WRITE.
- im_addr holds its last value when im_we=0.
- start outside IDLE/DONE/ERR is ignored.
- in_valid with in_ready=0 is ignored; the source must hold the byte until it is accepted.
- Byte gaps (in_valid=0) stall the state machine indefinitely; there is no timeout.
- Throughput: one word per 5 cycles minimum (4 transfers + 1 WRITE).
- Width rules:
  - im_addr is computed in 32 bits; it cannot wrap for N<=NMEM.
  - N comparison is 16-bit unsigned.
  - The word counter must be wide enough for NMEM (use $clog2(NMEM+1)).

Decomposition:
- Shared package/header holds:
  - the state encoding constants IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR;
  - WORD_BYTES=4;
  - the 16-bit header width.
- One sub-module is natural: im_loader_pack.
  - A 4-byte shift/assemble register with a byte counter.
  - It pulses word_ready when the 4th byte lands and is clearable on start or reset.
- The top level holds the FSM and address/word counters.

Test Plan:
- Basic load, NMEM=20, START_ADDR=0:
  - Stimulus: start, then bytes 00 03 | 20 00 00 00 | 20 80 00 00 | 01 00 08 20 with in_valid held high.
  - Response: three im_we pulses at addr 0, 4, 8 with data 32'h20000000, 32'h20800000, 32'h01000820. done=1 one cycle after the 3rd write; busy=0; in_ready low during each WRITE cycle.
- Zero length:
  - Stimulus: header 00 00.
  - Response: no im_we; done=1 the cycle after the 2nd byte is accepted.
- Overflow:
  - Stimulus: header 00 15 (21 > NMEM).
  - Response: err=1, no im_we, in_ready=0. A following start plus a valid 1-word image clears err and writes addr 0.
- Back-pressure/gaps:
  - Stimulus: in_valid toggled randomly; the source asserts in_valid during WRITE cycles.
  - Response: the byte offered during WRITE is not consumed; written words still match the expected stream exactly.
- Reset mid-load:
  - Stimulus: rst_n=0 after the 2nd data byte of word 1, then released.
  - Response: all outputs at reset values immediately (asynchronously); no im_we afterwards. A new start reloads correctly from addr START_ADDR.
- Offset base:
  - Stimulus: START_ADDR=32'h100, header 00 02, two words.
  - Response: writes at 32'h100 and 32'h104. start pulses during busy are ignored.
